// File: rtl/cci_host_mem_responder.sv
// cci_host_mem_responder
//
// Simulation-side host memory model for the simplified CCI-P interface.
// This is the FIU/host end that AFU test blocks talk to:
//   - c0 accepts line-read requests and returns the line data.
//   - c1 accepts line-write requests, commits them to memory and returns acks.
// Each channel has its own in-order response queue with a fixed minimum
// latency. A request that arrives while its queue is full is dropped and
// sets the sticky overflow flag.
//
// Optional feature macro: CCI_HOST_MEM_JITTER_EN
//   When defined, a 16-bit LFSR adds 0..3 extra cycles to each accepted
//   request's latency. Responses stay in order per channel. When undefined
//   there is no LFSR and latencies are exact.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   c0_req_valid/addr/mdata   read request (line address, tag)
//   c0_almfull            read queue almost full
//   c0_rsp_valid/data/mdata   read response (512-bit line, echoed tag)
//   c1_req_valid/addr/data/mdata  write request
//   c1_almfull            write queue almost full
//   c1_rsp_valid/mdata    write ack (echoed tag)
//   overflow              sticky: a request arrived while its queue was full

// Per-channel in-order response queue with a countdown per entry.
// The head pops once its countdown reaches zero, and the popped payload is
// presented on a registered response for one cycle.
module cci_rsp_queue #(
    parameter int PAYLOAD_W     = 16,
    parameter int LATENCY       = 4,
    parameter int QUEUE_DEPTH   = 8,
    parameter int ALMFULL_SLACK = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    input  logic [PAYLOAD_W-1:0] req_payload,
    input  logic [1:0]           jitter,
    output logic                 accept,
    output logic                 almfull,
    output logic                 overflow,
    output logic                 rsp_valid,
    output logic [PAYLOAD_W-1:0] rsp_payload
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = $clog2(LATENCY + 4);

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        ACTIVE = 2'd1,
        FULL   = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W:0]       count;
    logic [PTR_W:0]       count_next;
    logic                 pop;
    logic [CNT_W-1:0]     init_count;
    logic [PAYLOAD_W-1:0] payload_mem [QUEUE_DEPTH];
    logic [CNT_W-1:0]     countdown   [QUEUE_DEPTH];

    // Next-state logic: push when not full, pop when the head's countdown
    // has expired. A simultaneous push and pop leaves occupancy unchanged.
    always_comb begin
        accept     = 1'b0;
        pop        = 1'b0;
        count_next = count;
        state_next = state;
        init_count = CNT_W'(LATENCY - 1) + CNT_W'(jitter);

        accept = req_valid && (state != FULL);
        pop    = (state != EMPTY) && (countdown[rd_ptr] == '0);

        case ({accept, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase

        if (count_next == '0) begin
            state_next = EMPTY;
        end else if (count_next == (PTR_W + 1)'(QUEUE_DEPTH)) begin
            state_next = FULL;
        end else begin
            state_next = ACTIVE;
        end
    end

    // Control state, response register and sticky overflow. Reset discards
    // everything in flight; the entry storage itself needs no reset because
    // it is only read through valid pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= EMPTY;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            rsp_valid   <= 1'b0;
            rsp_payload <= '0;
            overflow    <= 1'b0;
        end else begin
            state     <= state_next;
            count     <= count_next;
            rsp_valid <= pop;
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr      <= rd_ptr + 1'b1;
                rsp_payload <= payload_mem[rd_ptr];
            end
            if (req_valid && (state == FULL)) begin
                overflow <= 1'b1;
            end
        end
    end

    // Entry storage. Every nonzero countdown ticks down each cycle, so a
    // younger entry that expires early simply waits behind the head. The
    // push assignment comes last so a freshly written slot takes its
    // initial countdown.
    always_ff @(posedge clk) begin
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            if (countdown[i] != '0) begin
                countdown[i] <= countdown[i] - 1'b1;
            end
        end
        if (accept) begin
            countdown[wr_ptr]   <= init_count;
            payload_mem[wr_ptr] <= req_payload;
        end
    end

    // Almost-full comes straight from the registered occupancy.
    always_comb begin
        almfull = (32'(QUEUE_DEPTH) - 32'(count)) <= 32'(ALMFULL_SLACK);
    end

endmodule

module cci_host_mem_responder #(
    parameter int DEPTH         = 64,
    parameter int ADDR_W        = 42,
    parameter int MDATA_W       = 16,
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 2,
    parameter int QUEUE_DEPTH   = 8,
    parameter int ALMFULL_SLACK = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               c0_req_valid,
    input  logic [ADDR_W-1:0]  c0_req_addr,
    input  logic [MDATA_W-1:0] c0_req_mdata,
    output logic               c0_almfull,
    output logic               c0_rsp_valid,
    output logic [511:0]       c0_rsp_data,
    output logic [MDATA_W-1:0] c0_rsp_mdata,
    input  logic               c1_req_valid,
    input  logic [ADDR_W-1:0]  c1_req_addr,
    input  logic [511:0]       c1_req_data,
    input  logic [MDATA_W-1:0] c1_req_mdata,
    output logic               c1_almfull,
    output logic               c1_rsp_valid,
    output logic [MDATA_W-1:0] c1_rsp_mdata,
    output logic               overflow
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [511:0]         mem [DEPTH];
    logic [IDX_W-1:0]     c0_idx;
    logic [IDX_W-1:0]     c1_idx;
    logic [1:0]           jitter;
    logic                 c0_accept;
    logic                 c1_accept;
    logic                 c0_overflow;
    logic                 c1_overflow;
    logic [511+MDATA_W:0] c0_rsp_payload;
    logic                 unused_ok;

    // Upper address bits are ignored, so addresses wrap around memory.
    assign c0_idx = c0_req_addr[IDX_W-1:0];
    assign c1_idx = c1_req_addr[IDX_W-1:0];

    assign unused_ok = ^{c0_req_addr[ADDR_W-1:IDX_W], c1_req_addr[ADDR_W-1:IDX_W], c0_accept};

`ifdef CCI_HOST_MEM_JITTER_EN
    logic [15:0] lfsr;

    // Fibonacci LFSR for x^16+x^14+x^13+x^11+1, free-running every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign jitter = lfsr[1:0];
`else
    assign jitter = 2'b00;
`endif

    // Memory is deliberately not reset so that data survives a reset.
    // The read path samples the array combinationally in the accept cycle,
    // so a same-cycle write to the same line is seen only by later reads.
    always_ff @(posedge clk) begin
        if (c1_accept) begin
            mem[c1_idx] <= c1_req_data;
        end
    end

    cci_rsp_queue #(
        .PAYLOAD_W     (512 + MDATA_W),
        .LATENCY       (READ_LATENCY),
        .QUEUE_DEPTH   (QUEUE_DEPTH),
        .ALMFULL_SLACK (ALMFULL_SLACK)
    ) u_c0_queue (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (c0_req_valid),
        .req_payload ({mem[c0_idx], c0_req_mdata}),
        .jitter      (jitter),
        .accept      (c0_accept),
        .almfull     (c0_almfull),
        .overflow    (c0_overflow),
        .rsp_valid   (c0_rsp_valid),
        .rsp_payload (c0_rsp_payload)
    );

    assign c0_rsp_data  = c0_rsp_payload[511+MDATA_W:MDATA_W];
    assign c0_rsp_mdata = c0_rsp_payload[MDATA_W-1:0];

    cci_rsp_queue #(
        .PAYLOAD_W     (MDATA_W),
        .LATENCY       (WRITE_LATENCY),
        .QUEUE_DEPTH   (QUEUE_DEPTH),
        .ALMFULL_SLACK (ALMFULL_SLACK)
    ) u_c1_queue (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (c1_req_valid),
        .req_payload (c1_req_mdata),
        .jitter      (jitter),
        .accept      (c1_accept),
        .almfull     (c1_almfull),
        .overflow    (c1_overflow),
        .rsp_valid   (c1_rsp_valid),
        .rsp_payload (c1_rsp_mdata)
    );

    assign overflow = c0_overflow | c1_overflow;

endmodule

// File: tb/tb_cci_host_mem_responder.sv
// tb_cci_host_mem_responder
//
// Self-checking bench for cci_host_mem_responder. A behavioural model keeps
// a line memory plus a list of expected responses per channel, each with the
// time window in which it must appear. A negedge monitor pairs DUT responses
// with that list; directed steps check reset, almost-full, overflow and the
// reset-retains-memory behaviour.
module tb_cci_host_mem_responder;

    localparam int DEPTH   = 64;
    localparam int ADDR_W  = 42;
    localparam int MDATA_W = 16;
    localparam int RD_LAT  = 12;
    localparam int WR_LAT  = 2;
    localparam int QD      = 8;
    localparam int SLACK   = 2;
`ifdef CCI_HOST_MEM_JITTER_EN
    localparam int JIT = 3;
`else
    localparam int JIT = 0;
`endif

    logic               clk = 1'b0;
    logic               reset;
    logic               c0_req_valid;
    logic [ADDR_W-1:0]  c0_req_addr;
    logic [MDATA_W-1:0] c0_req_mdata;
    logic               c0_almfull;
    logic               c0_rsp_valid;
    logic [511:0]       c0_rsp_data;
    logic [MDATA_W-1:0] c0_rsp_mdata;
    logic               c1_req_valid;
    logic [ADDR_W-1:0]  c1_req_addr;
    logic [511:0]       c1_req_data;
    logic [MDATA_W-1:0] c1_req_mdata;
    logic               c1_almfull;
    logic               c1_rsp_valid;
    logic [MDATA_W-1:0] c1_rsp_mdata;
    logic               overflow;

    always #5 clk = ~clk;

    cci_host_mem_responder #(
        .DEPTH         (DEPTH),
        .ADDR_W        (ADDR_W),
        .MDATA_W       (MDATA_W),
        .READ_LATENCY  (RD_LAT),
        .WRITE_LATENCY (WR_LAT),
        .QUEUE_DEPTH   (QD),
        .ALMFULL_SLACK (SLACK)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .c0_req_valid (c0_req_valid),
        .c0_req_addr  (c0_req_addr),
        .c0_req_mdata (c0_req_mdata),
        .c0_almfull   (c0_almfull),
        .c0_rsp_valid (c0_rsp_valid),
        .c0_rsp_data  (c0_rsp_data),
        .c0_rsp_mdata (c0_rsp_mdata),
        .c1_req_valid (c1_req_valid),
        .c1_req_addr  (c1_req_addr),
        .c1_req_data  (c1_req_data),
        .c1_req_mdata (c1_req_mdata),
        .c1_almfull   (c1_almfull),
        .c1_rsp_valid (c1_rsp_valid),
        .c1_rsp_mdata (c1_rsp_mdata),
        .overflow     (overflow)
    );

    typedef struct {
        time                acc;
        logic [MDATA_W-1:0] mdata;
        logic [511:0]       data;
    } exp_t;

    exp_t         exp_rd[$];
    exp_t         exp_wr[$];
    logic [511:0] model_mem [DEPTH];
    bit           exp_overflow = 1'b0;
    int           checks = 0;
    int           fails = 0;
    int           rd_rsp_count = 0;
    time          last_rd = 0;
    time          last_wr = 0;

    task automatic checkOutput(input string tag, input logic [511:0] observed,
                               input logic [511:0] expected);
        checks++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic time tmax(input time a, input time b);
        return (a > b) ? a : b;
    endfunction

    // Entries still held in the DUT at the edge at time edge_t: those whose
    // latest possible pop edge is not before edge_t.
    function automatic int occupancy(input exp_t q[$], input time edge_t, input int lat);
        int n = 0;
        foreach (q[i]) if (q[i].acc + time'(lat * 10) >= edge_t) n++;
        return n;
    endfunction

    // Drives one cycle of requests starting at a negedge and updates the
    // model: read data is captured before the same-cycle write lands.
    task automatic applyStimulus(input bit rv, input logic [ADDR_W-1:0] ra,
                                 input logic [MDATA_W-1:0] rm, input bit wv,
                                 input logic [ADDR_W-1:0] wa, input logic [511:0] wd,
                                 input logic [MDATA_W-1:0] wm);
        time  t_edge = $time + 5;
        exp_t e;
        c0_req_valid = rv;
        c0_req_addr  = ra;
        c0_req_mdata = rm;
        c1_req_valid = wv;
        c1_req_addr  = wa;
        c1_req_data  = wd;
        c1_req_mdata = wm;
        if (rv) begin
            if (occupancy(exp_rd, t_edge, RD_LAT + JIT) < QD) begin
                e.acc = t_edge; e.mdata = rm; e.data = model_mem[ra[5:0]];
                exp_rd.push_back(e);
            end else begin
                exp_overflow = 1'b1;
            end
        end
        if (wv) begin
            if (occupancy(exp_wr, t_edge, WR_LAT + JIT) < QD) begin
                e.acc = t_edge; e.mdata = wm; e.data = '0;
                exp_wr.push_back(e);
                model_mem[wa[5:0]] = wd;
            end else begin
                exp_overflow = 1'b1;
            end
        end
        @(negedge clk);
        c0_req_valid = 1'b0;
        c1_req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && (exp_rd.size() != 0 || exp_wr.size() != 0); i++)
            @(negedge clk);
        checkOutput("drain", 512'(exp_rd.size() + exp_wr.size()), 512'd0);
    endtask

    // Response monitor: each response must fall in its model window, in
    // order, with the right tag and data; a window that expires unmet counts
    // as a missing response.
    always @(negedge clk) begin
        exp_t e;
        time  lo;
        time  hi;
        if (!reset) begin
            if (c0_rsp_valid) begin
                rd_rsp_count++;
                if (exp_rd.size() == 0) begin
                    checkOutput("c0 unexpected rsp", 512'd1, 512'd0);
                end else begin
                    e  = exp_rd.pop_front();
                    lo = tmax(e.acc + RD_LAT * 10 + 5, last_rd + 10);
                    hi = tmax(e.acc + (RD_LAT + JIT) * 10 + 5, last_rd + 10);
                    checkOutput("c0 rsp timing", 512'($time >= lo && $time <= hi), 512'd1);
                    checkOutput("c0 rsp mdata", 512'(c0_rsp_mdata), 512'(e.mdata));
                    checkOutput("c0 rsp data", c0_rsp_data, e.data);
                end
                last_rd = $time;
            end else if (exp_rd.size() != 0) begin
                hi = tmax(exp_rd[0].acc + (RD_LAT + JIT) * 10 + 5, last_rd + 10);
                if ($time >= hi) begin
                    checkOutput("c0 rsp missing", 512'd0, 512'd1);
                    void'(exp_rd.pop_front());
                    last_rd = $time;
                end
            end
            if (c1_rsp_valid) begin
                if (exp_wr.size() == 0) begin
                    checkOutput("c1 unexpected ack", 512'd1, 512'd0);
                end else begin
                    e  = exp_wr.pop_front();
                    lo = tmax(e.acc + WR_LAT * 10 + 5, last_wr + 10);
                    hi = tmax(e.acc + (WR_LAT + JIT) * 10 + 5, last_wr + 10);
                    checkOutput("c1 ack timing", 512'($time >= lo && $time <= hi), 512'd1);
                    checkOutput("c1 ack mdata", 512'(c1_rsp_mdata), 512'(e.mdata));
                end
                last_wr = $time;
            end else if (exp_wr.size() != 0) begin
                hi = tmax(exp_wr[0].acc + (WR_LAT + JIT) * 10 + 5, last_wr + 10);
                if ($time >= hi) begin
                    checkOutput("c1 ack missing", 512'd0, 512'd1);
                    void'(exp_wr.pop_front());
                    last_wr = $time;
                end
            end
        end
    end

    // Directed sequence with randomized data and addresses.
    initial begin
        logic [511:0] a_data;
        logic [511:0] x_data;
        int           base_count;

        reset        = 1'b1;
        c0_req_valid = 1'b0;
        c0_req_addr  = '0;
        c0_req_mdata = '0;
        c1_req_valid = 1'b0;
        c1_req_addr  = '0;
        c1_req_data  = '0;
        c1_req_mdata = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        $display("[TB] reset state");
        checkOutput("reset c0_rsp_valid", 512'(c0_rsp_valid), 512'd0);
        checkOutput("reset c1_rsp_valid", 512'(c1_rsp_valid), 512'd0);
        checkOutput("reset c0_almfull", 512'(c0_almfull), 512'd0);
        checkOutput("reset c1_almfull", 512'(c1_almfull), 512'd0);
        checkOutput("reset overflow", 512'(overflow), 512'd0);
        checkOutput("reset c0_rsp_data", c0_rsp_data, 512'd0);
        checkOutput("reset c0_rsp_mdata", 512'(c0_rsp_mdata), 512'd0);
        checkOutput("reset c1_rsp_mdata", 512'(c1_rsp_mdata), 512'd0);

        $display("[TB] preload every line");
        for (int i = 0; i < DEPTH; i++)
            applyStimulus(0, '0, '0, 1, ADDR_W'(i), rand512(), MDATA_W'($urandom));
        drain();

        $display("[TB] write then read");
        applyStimulus(0, '0, '0, 1, 42'd5, {448'd0, 32'd7, 32'd6}, 16'd3);
        drain();
        applyStimulus(1, 42'd5, 16'd9, 0, '0, '0, '0);
        drain();
        checkOutput("idle hold c0_rsp_mdata", 512'(c0_rsp_mdata), 512'd9);
        checkOutput("idle hold c0_rsp_data", 512'(c0_rsp_data[63:0]), {448'd0, 32'd7, 32'd6});
        checkOutput("idle hold c1_rsp_mdata", 512'(c1_rsp_mdata), 512'd3);

        $display("[TB] read-first collision");
        a_data = rand512();
        applyStimulus(0, '0, '0, 1, 42'd2, a_data, 16'h20);
        drain();
        applyStimulus(1, 42'd2, 16'h21, 1, 42'd2, rand512(), 16'h22);
        applyStimulus(1, 42'd2, 16'h23, 0, '0, '0, '0);
        drain();

        $display("[TB] burst to full");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, ADDR_W'($urandom_range(0, DEPTH - 1)), MDATA_W'(i), 0, '0, '0, '0);
            if (i == 4) checkOutput("almfull after 5", 512'(c0_almfull), 512'd0);
            if (i == 5) checkOutput("almfull after 6", 512'(c0_almfull), 512'd1);
        end
        checkOutput("overflow before 9th", 512'(overflow), 512'(exp_overflow));
        applyStimulus(1, 42'd1, 16'd8, 0, '0, '0, '0);
        checkOutput("overflow after 9th", 512'(overflow), 512'(exp_overflow));
        checkOutput("almfull while full", 512'(c0_almfull), 512'd1);
        drain();
        checkOutput("almfull after drain", 512'(c0_almfull), 512'd0);

        $display("[TB] address wrap");
        x_data = rand512();
        applyStimulus(0, '0, '0, 1, ADDR_W'(DEPTH + 3), x_data, 16'h30);
        applyStimulus(1, 42'd3, 16'h31, 0, '0, '0, '0);
        drain();

        $display("[TB] reset mid-flight");
        for (int i = 0; i < 3; i++)
            applyStimulus(1, ADDR_W'(i + 10), MDATA_W'(16'h40 + i), 0, '0, '0, '0);
        @(negedge clk);
        reset = 1'b1;
        exp_rd.delete();
        exp_wr.delete();
        exp_overflow = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("post-reset c0_almfull", 512'(c0_almfull), 512'd0);
        checkOutput("post-reset overflow", 512'(overflow), 512'(exp_overflow));
        checkOutput("post-reset c0_rsp_valid", 512'(c0_rsp_valid), 512'd0);
        repeat (RD_LAT + JIT + 4) @(negedge clk);
        applyStimulus(1, ADDR_W'(DEPTH + 3), 16'h50, 0, '0, '0, '0);
        drain();

        $display("[TB] spaced random reads with random writes");
        base_count = rd_rsp_count;
        for (int i = 0; i < 48; i++) begin
            applyStimulus(i % 3 == 0, ADDR_W'($urandom_range(0, DEPTH * 4 - 1)),
                          MDATA_W'(16'h100 + i), $urandom_range(0, 1) == 1,
                          ADDR_W'($urandom_range(0, DEPTH * 4 - 1)), rand512(),
                          MDATA_W'($urandom));
        end
        drain();
        checkOutput("random read count", 512'(rd_rsp_count - base_count), 512'd16);
        checkOutput("final overflow", 512'(overflow), 512'(exp_overflow));

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
